// File: rtl/deadzone_mc_if.sv
// ============================================================================
// deadzone_mc_if : configuration, reference and output bundle of deadzone_mc
// Revision 1.0
// ============================================================================
`default_nettype none

interface deadzone_mc_if #(
   parameter int CH_NUM = 4,
   parameter int DTW    = 10
);
   logic [CH_NUM-1:0]     r_dze;
   logic [CH_NUM-1:0]     r_ccp;
   logic [CH_NUM-1:0]     r_ccnp;
   logic [CH_NUM*DTW-1:0] r_dtg_r;
   logic [CH_NUM*DTW-1:0] r_dtg_f;
   logic                  upd_evt;
   logic                  brk;
   logic [CH_NUM-1:0]     ocref;
   logic [CH_NUM-1:0]     channelp_out;
   logic [CH_NUM-1:0]     channeln_out;
   logic [CH_NUM-1:0]     dz_active;

   modport master (
      output r_dze, r_ccp, r_ccnp, r_dtg_r, r_dtg_f, upd_evt, brk, ocref,
      input  channelp_out, channeln_out, dz_active
   );

   modport slave (
      input  r_dze, r_ccp, r_ccnp, r_dtg_r, r_dtg_f, upd_evt, brk, ocref,
      output channelp_out, channeln_out, dz_active
   );
endinterface

`default_nettype wire

// File: rtl/deadzone_mc.sv
// ============================================================================
// deadzone_mc : multi-channel complementary dead-time inserter with break
// Revision 1.0
// ============================================================================
`default_nettype none

module deadzone_mc #(
   parameter int CH_NUM = 4,
   parameter int DTW    = 10
) (
   input  wire logic          pe_gen_clk,
   input  wire logic          pe_gen_rst,
   deadzone_mc_if.slave       bus
);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_DEAD_R = 3'd1,
      ST_P_ON   = 3'd2,
      ST_DEAD_F = 3'd3,
      ST_N_ON   = 3'd4
   } state_t;

   logic [CH_NUM-1:0] w_rawp;
   logic [CH_NUM-1:0] w_rawn;
   logic [CH_NUM-1:0] w_dz;

   generate
      for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
         state_t           r_state;
         state_t           w_state_nxt;
         logic [DTW-1:0]   r_cnt;
         logic [DTW-1:0]   w_cnt_nxt;
         logic [DTW-1:0]   r_sh_r;
         logic [DTW-1:0]   r_sh_f;
         logic             r_ocref_d;
         logic             r_rawp;
         logic             r_rawn;
         logic             r_dz;
         logic             w_ocref;
         logic             w_rise;
         logic             w_fall;

         assign w_ocref = bus.ocref[g];
         assign w_rise  = w_ocref & ~r_ocref_d;
         assign w_fall  = ~w_ocref & r_ocref_d;

         // Edge loads read the shadow register, so an update on the same edge
         // only takes effect at the following edge.
         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (bus.brk) begin
               w_state_nxt = ST_OFF;
               w_cnt_nxt   = '0;
            end else if (r_state == ST_OFF || (bus.r_dze[g] && (w_rise || w_fall))) begin
               if (w_ocref) begin
                  w_state_nxt = (r_sh_r == '0) ? ST_P_ON : ST_DEAD_R;
                  w_cnt_nxt   = r_sh_r;
               end else begin
                  w_state_nxt = (r_sh_f == '0) ? ST_N_ON : ST_DEAD_F;
                  w_cnt_nxt   = r_sh_f;
               end
            end else if (!bus.r_dze[g]) begin
               w_state_nxt = w_ocref ? ST_P_ON : ST_N_ON;
               w_cnt_nxt   = '0;
            end else if (r_state == ST_DEAD_R || r_state == ST_DEAD_F) begin
               if (r_cnt > DTW'(1)) begin
                  w_cnt_nxt = r_cnt - DTW'(1);
               end else begin
                  w_state_nxt = (r_state == ST_DEAD_R) ? ST_P_ON : ST_N_ON;
                  w_cnt_nxt   = '0;
               end
            end
         end

         always_ff @(posedge pe_gen_clk) begin
            if (pe_gen_rst) begin
               r_state   <= ST_OFF;
               r_cnt     <= '0;
               r_ocref_d <= 1'b0;
               r_sh_r    <= bus.r_dtg_r[g*DTW +: DTW];
               r_sh_f    <= bus.r_dtg_f[g*DTW +: DTW];
               r_rawp    <= 1'b0;
               r_rawn    <= 1'b0;
               r_dz      <= 1'b0;
            end else begin
               r_ocref_d <= w_ocref;
               if (bus.upd_evt) begin
                  r_sh_r <= bus.r_dtg_r[g*DTW +: DTW];
                  r_sh_f <= bus.r_dtg_f[g*DTW +: DTW];
               end
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
               r_rawp  <= (w_state_nxt == ST_P_ON);
               r_rawn  <= (w_state_nxt == ST_N_ON);
               r_dz    <= (w_state_nxt == ST_DEAD_R) || (w_state_nxt == ST_DEAD_F);
            end
         end

         assign w_rawp[g] = r_rawp;
         assign w_rawn[g] = r_rawn;
         assign w_dz[g]   = r_dz;
      end
   endgenerate

   assign bus.channelp_out = w_rawp ^ bus.r_ccp;
   assign bus.channeln_out = w_rawn ^ bus.r_ccnp;
   assign bus.dz_active    = w_dz;

endmodule

`default_nettype wire

// File: tb/tb_deadzone_mc.sv
// ============================================================================
// tb_deadzone_mc : directed scoreboard bench for deadzone_mc
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_deadzone_mc;

   localparam int CH  = 4;
   localparam int DTW = 10;

   typedef struct {
      int    cyc;
      int    ch;
      logic  p;
      logic  n;
      logic  dz;
      string tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   deadzone_mc_if #(.CH_NUM(CH), .DTW(DTW)) bus ();

   deadzone_mc #(.CH_NUM(CH), .DTW(DTW)) dut (
      .pe_gen_clk (clk),
      .pe_gen_rst (rst),
      .bus        (bus)
   );

   // Monitor: compare every expectation that falls due in the current cycle.
   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            checks++;
            if (bus.channelp_out[q[i].ch] !== q[i].p || bus.channeln_out[q[i].ch] !== q[i].n ||
                bus.dz_active[q[i].ch] !== q[i].dz) begin
               failures++;
               $display("FAIL %s cyc=%0d ch=%0d actual p/n/dz=%b%b%b required=%b%b%b",
                        q[i].tag, cyc, q[i].ch, bus.channelp_out[q[i].ch],
                        bus.channeln_out[q[i].ch], bus.dz_active[q[i].ch],
                        q[i].p, q[i].n, q[i].dz);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s stale cyc=%0d ch=%0d actual=unsampled required=cyc %0d",
                     q[i].tag, cyc, q[i].ch, q[i].cyc);
            q.delete(i);
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Raw levels for a window of cycles; polarity applied from current settings.
   task automatic ph(input int ch, input int c0, input int len, input bit p, input bit n,
                     input bit dz, input string tag);
      for (int k = 0; k < len; k++) begin
         exp_t e;
         e.cyc = c0 + k;
         e.ch  = ch;
         e.p   = p ^ bus.r_ccp[ch];
         e.n   = n ^ bus.r_ccnp[ch];
         e.dz  = dz;
         e.tag = tag;
         q.push_back(e);
      end
   endtask

   initial begin
      int c;
      bus.r_dze   = 4'b1111;
      bus.r_ccp   = 4'b0000;
      bus.r_ccnp  = 4'b1111;
      bus.r_dtg_r = {10'd2, 10'd7, 10'd4, 10'd5};
      bus.r_dtg_f = {10'd2, 10'd7, 10'd3, 10'd3};
      bus.upd_evt = 1'b0;
      bus.brk     = 1'b0;
      bus.ocref   = 4'b0000;

      // Reset, then release into a full falling dead time.
      step(2);
      c = cyc;
      for (int ch = 0; ch < CH; ch++) ph(ch, c, 1, 0, 0, 0, "reset");
      rst = 1'b0;
      ph(0, c + 1, 3, 0, 0, 1, "rel_dz0");  ph(0, c + 4, 10, 0, 1, 0, "rel_n0");
      ph(1, c + 1, 3, 0, 0, 1, "rel_dz1");  ph(1, c + 4, 10, 0, 1, 0, "rel_n1");
      ph(2, c + 1, 7, 0, 0, 1, "rel_dz2");  ph(2, c + 8, 6, 0, 1, 0, "rel_n2");
      ph(3, c + 1, 2, 0, 0, 1, "rel_dz3");  ph(3, c + 3, 11, 0, 1, 0, "rel_n3");
      step(16);

      // Channel 0 toggling every 20 cycles: 5-cycle rise gap, 3-cycle fall gap.
      for (int p = 0; p < 2; p++) begin
         c = cyc;
         bus.ocref[0] = 1'b1;
         ph(0, c + 1, 5, 0, 0, 1, "tog_rdz");
         ph(0, c + 6, 15, 1, 0, 0, "tog_p");
         step(20);
         c = cyc;
         bus.ocref[0] = 1'b0;
         ph(0, c + 1, 3, 0, 0, 1, "tog_fdz");
         ph(0, c + 4, 17, 0, 1, 0, "tog_n");
         step(20);
      end

      // Short pulse on channel 1: P never asserts, fall restarts full 3 cycles.
      c = cyc;
      ph(1, c + 1, 5, 0, 0, 1, "pulse_dz");
      ph(1, c + 6, 6, 0, 1, 0, "pulse_n");
      bus.ocref[1] = 1'b1;
      step(2);
      bus.ocref[1] = 1'b0;
      step(12);

      // Update coincident with a rise: old gap 5 now, new gap 8 next time.
      c = cyc;
      bus.ocref[0]      = 1'b1;
      bus.r_dtg_r[9:0]  = 10'd8;
      bus.upd_evt       = 1'b1;
      ph(0, c + 1, 5, 0, 0, 1, "upd_old_dz");
      ph(0, c + 6, 15, 1, 0, 0, "upd_p");
      step(1);
      bus.upd_evt = 1'b0;
      step(19);
      bus.ocref[0] = 1'b0;
      ph(0, c + 21, 3, 0, 0, 1, "upd_fdz");
      ph(0, c + 24, 17, 0, 1, 0, "upd_n");
      step(20);
      bus.ocref[0] = 1'b1;
      ph(0, c + 41, 8, 0, 0, 1, "upd_new_dz");
      ph(0, c + 49, 12, 1, 0, 0, "upd_p2");
      step(21);

      // Break with all channels P_ON and mixed polarity.
      c = cyc;
      bus.r_ccp  = 4'b0101;
      bus.r_ccnp = 4'b1001;
      bus.ocref  = 4'b1111;
      ph(0, c + 1, 10, 1, 0, 0, "pre_p0");
      ph(1, c + 1, 4, 0, 0, 1, "pre_dz1");  ph(1, c + 5, 6, 1, 0, 0, "pre_p1");
      ph(2, c + 1, 7, 0, 0, 1, "pre_dz2");  ph(2, c + 8, 3, 1, 0, 0, "pre_p2");
      ph(3, c + 1, 2, 0, 0, 1, "pre_dz3");  ph(3, c + 3, 8, 1, 0, 0, "pre_p3");
      step(10);
      bus.brk = 1'b1;
      for (int ch = 0; ch < CH; ch++) ph(ch, c + 11, 5, 0, 0, 0, "brk");
      step(5);
      bus.brk = 1'b0;
      ph(0, c + 16, 8, 0, 0, 1, "brel_dz0");  ph(0, c + 24, 3, 1, 0, 0, "brel_p0");
      ph(1, c + 16, 4, 0, 0, 1, "brel_dz1");  ph(1, c + 20, 7, 1, 0, 0, "brel_p1");
      ph(2, c + 16, 7, 0, 0, 1, "brel_dz2");  ph(2, c + 23, 4, 1, 0, 0, "brel_p2");
      ph(3, c + 16, 2, 0, 0, 1, "brel_dz3");  ph(3, c + 18, 9, 1, 0, 0, "brel_p3");
      step(11);

      // Bypass on channel 2: one-cycle tracking, other channels stay P_ON.
      c = cyc;
      bus.r_dze[2] = 1'b0;
      bus.ocref[2] = 1'b0;
      ph(2, c + 1, 3, 0, 1, 0, "byp_n_a");
      ph(2, c + 4, 1, 1, 0, 0, "byp_p_a");
      ph(2, c + 5, 2, 0, 1, 0, "byp_n_b");
      ph(2, c + 7, 4, 1, 0, 0, "byp_p_b");
      ph(0, c + 1, 10, 1, 0, 0, "byp_oth0");
      ph(1, c + 1, 10, 1, 0, 0, "byp_oth1");
      ph(3, c + 1, 10, 1, 0, 0, "byp_oth3");
      step(3);
      bus.ocref[2] = 1'b1;
      step(1);
      bus.ocref[2] = 1'b0;
      step(2);
      bus.ocref[2] = 1'b1;
      step(4);

      step(3);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/deadzone_mc.md
# deadzone_mc

Parametrised multi-channel dead-time inserter for the advanced timer pulse-engine core. It takes `CH_NUM` PWM reference signals and produces complementary P/N output pairs. Each pair has independent rising-edge and falling-edge dead times, per-output polarity, shadowed dead-time registers updated on a timer update event, and a break input that forces the safe inactive state. It sits between the compare/ocref generation stage and the output pin mux, one instance per timer.

## Interface
- `CH_NUM`, 4, number of channels (1..8)
- `DTW`, 10, dead-time counter width in bits
- `pe_gen_clk`  in  1  pulse-engine clock
- `pe_gen_rst`  in  1  reset, synchronous, active-high
- `r_dze`  in  CH_NUM  per-channel dead-zone enable
- `r_ccp`  in  CH_NUM  P output polarity (1 = active-low)
- `r_ccnp`  in  CH_NUM  N output polarity (1 = active-low)
- `r_dtg_r`  in  CH_NUM*DTW  rising-edge dead time, channel i at `[i*DTW +: DTW]`
- `r_dtg_f`  in  CH_NUM*DTW  falling-edge dead time, same packing
- `upd_evt`  in  1  one-cycle pulse; loads `r_dtg_r`/`r_dtg_f` into shadow registers
- `brk`  in  1  break; forces all outputs inactive while high
- `ocref`  in  CH_NUM  reference waveforms, synchronous to `pe_gen_clk`
- `channelp_out`  out  CH_NUM  P output after dead time and polarity
- `channeln_out`  out  CH_NUM  N output after dead time and polarity
- `dz_active`  out  CH_NUM  channel currently inside a dead-time interval

## Operation
- Per channel, `ocref_d` register; rise = `ocref & ~ocref_d`, fall = `~ocref & ocref_d`.
- Per channel FSM states and outputs:
  - OFF: P and N both inactive.
  - DEAD_R: both inactive, counting the rising dead time.
  - P_ON: P active.
  - DEAD_F: both inactive, counting the falling dead time.
  - N_ON: N active.
- Raw P = (state == P_ON). Raw N = (state == N_ON).
- `channelp_out` = rawP ^ `r_ccp`. `channeln_out` = rawN ^ `r_ccnp`. Outputs decode from the state register only.
- `dz_active` = state in {DEAD_R, DEAD_F}.
- Transitions, in priority order (highest first):
  - brk = 1: go to OFF, counter cleared.
  - State OFF with brk = 0: if `ocref` = 1, go to DEAD_R and load `cnt` = shadow_r. If `ocref` = 0, go to DEAD_F and load `cnt` = shadow_f. A loaded value of 0 goes directly to P_ON or N_ON.
  - `r_dze` = 0 (bypass): state = `ocref` ? P_ON : N_ON, counter held at 0.
  - rise: go to DEAD_R and load shadow_r. If shadow_r = 0, go directly to P_ON. This applies from any state, including DEAD_F.
  - fall: go to DEAD_F and load shadow_f. If shadow_f = 0, go directly to N_ON. This applies from any state, including DEAD_R.
  - DEAD_R/DEAD_F with `cnt` > 1: decrement. With `cnt` = 1: go to P_ON/N_ON and clear `cnt`.
- Pulse shorter than the dead time: the active output never asserts, and the opposite edge restarts with the full opposite dead time.
- Counter arithmetic is unsigned `DTW`-bit. The counter never wraps; the maximum dead time is 2^DTW−1 cycles.
- Shadow registers:
  - Loaded on `upd_evt` and on reset.
  - A load coincident with an edge uses the OLD shadow value; the new value applies from the next edge.
  - A dead-time interval in progress is unaffected by `upd_evt`.
- `r_dze` 1→0 during a dead time: take bypass on the next edge. `r_dze` 0→1: continue from P_ON/N_ON until the next edge.

## Timing
- Reset (`pe_gen_rst` = 1 at a clock edge):
  - state = OFF, `ocref_d` = 0, `cnt` = 0, shadows = `r_dtg_*`.
  - `channelp_out` = `r_ccp`, `channeln_out` = `r_ccnp`, `dz_active` = 0.
- Reset mid-operation discards any dead time in progress, with the same values as above.
- First edge after reset release with brk = 0: leave OFF per the current `ocref`, with a full dead time.
- `ocref` rises at clock edge k (sampled: `ocref` = 1, `ocref_d` = 0 before edge k+1):
  - N deasserts at edge k+1.
  - P asserts at edge k+1+D, where D = shadow_r.
  - Both outputs are inactive for exactly D cycles. The falling edge is symmetric with shadow_f.
- Bypass latency: 1 cycle from `ocref` to the outputs.
- brk takes effect at the next edge (1 cycle). Release restarts with a full dead time as in OFF.

## Test plan
- Reset, `r_ccp` = 0, `r_ccnp` = 1 → `channelp_out` = 0, `channeln_out` = 1, `dz_active` = 0.
- Channel 0, shadow_r = 5, shadow_f = 3, `ocref` toggling every 20 cycles → N falls 1 cycle after the rise, P rises 5 cycles later, and P→N has a 3-cycle gap. `dz_active` is high for exactly 5 and 3 cycles respectively.
- `ocref` high pulse of 2 cycles with shadow_r = 4 → P never asserts, DEAD_F restarts with 3, and N returns after 3 cycles.
- `upd_evt` coincident with a rise, `r_dtg_r` changing 5→8 → this gap is 5 cycles, and the next rising gap is 8 cycles.
- brk asserted while P_ON on 4 channels with mixed polarity → all outputs go to their polarity level within 1 cycle. On release with `ocref` = 1, P returns after the full shadow_r.
- `r_dze` = 0 on channel 2, shadow = 7 → `channelp_out`/`channeln_out` track `ocref`/~`ocref` with 1-cycle latency and `dz_active` = 0. Channels 0, 1 and 3 are unaffected.
